// File: rtl/sram_controller.sv
// sram_controller: sequences the external 256K x 16 asynchronous SRAM for the
// cache controller. A 64-bit line read becomes four halfword reads and a 32-bit
// word write becomes two halfword writes; completion is a one-cycle sram_ready.
// Optional build macro SRAM_POSTED_WRITE_EN: writes are acknowledged in the
// first WRITE cycle and finish in the background.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] sram_address,
  input  logic [31:0] sram_wdata,
  input  logic        sram_r_en,
  input  logic        sram_w_en,
  output logic [63:0] sram_rdata,
  output logic        sram_ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e        state_q;
  logic [1:0]    phase_q;
  logic [1:0]    phase_d;
  logic [CW-1:0] wait_q;
  logic          wait_done;
  logic [15:0]   addr_q;      // halfword-pair address, sram_address[17:2]
  logic [15:0]   whi_q;       // upper half of the accepted write word
  logic [63:0]   rdata_q;
  logic          ready_q;
  logic [17:0]   sram_addr_q;
  logic          we_n_q;
  logic          oe_n_q;
  logic          dq_oe_q;
  logic [15:0]   dq_out_q;
  logic          unused_addr_lsbs;

  // Byte offset within a word is meaningless to a halfword SRAM.
  assign unused_addr_lsbs = ^sram_address[1:0];

  assign phase_d   = phase_q + 2'd1;
  assign wait_done = (wait_q == WAIT_LAST);

  // Main sequencer: state, phase/wait counters and all registered pin values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      wait_q      <= '0;
      addr_q      <= '0;
      whi_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          phase_q <= '0;
          wait_q  <= '0;
          if (sram_w_en) begin
            // Write has priority; first halfword is set up on the accept edge.
            state_q     <= WRITE;
            addr_q      <= sram_address[17:2];
            whi_q       <= sram_wdata[31:16];
            sram_addr_q <= {1'b0, sram_address[17:2], 1'b0};
            we_n_q      <= 1'b0;
            oe_n_q      <= 1'b1;
            dq_oe_q     <= 1'b1;
            dq_out_q    <= sram_wdata[15:0];
`ifdef SRAM_POSTED_WRITE_EN
            ready_q     <= 1'b1;
`endif
          end else if (sram_r_en) begin
            state_q     <= READ;
            addr_q      <= sram_address[17:2];
            sram_addr_q <= {1'b0, sram_address[17:3], 2'b00};
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b0;
          end
        end

        READ: begin
          if (wait_done) begin
            rdata_q[{phase_q, 4'b0000} +: 16] <= SRAM_DQ;
            wait_q <= '0;
            if (phase_q == 2'd3) begin
              state_q <= DONE;
              oe_n_q  <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              phase_q     <= phase_d;
              sram_addr_q <= {1'b0, addr_q[15:1], phase_d};
            end
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end

        WRITE: begin
          if (wait_done) begin
            wait_q <= '0;
            if (phase_q[0]) begin
              state_q <= DONE;
              we_n_q  <= 1'b1;
              dq_oe_q <= 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
              ready_q <= 1'b0;
`else
              ready_q <= 1'b1;
`endif
            end else begin
              phase_q     <= 2'd1;
              sram_addr_q <= {1'b0, addr_q, 1'b1};
              dq_out_q    <= whi_q;
            end
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SRAM_DQ    = dq_oe_q ? dq_out_q : 'z;
  assign SRAM_ADDR  = sram_addr_q;
  assign SRAM_WE_N  = we_n_q;
  assign SRAM_OE_N  = oe_n_q;
  assign SRAM_CE_N  = 1'b0;
  assign SRAM_UB_N  = 1'b0;
  assign SRAM_LB_N  = 1'b0;
  assign sram_rdata = rdata_q;
  assign sram_ready = ready_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed scoreboard bench for sram_controller with two
// instances (WAIT_CYCLES = 1 and 3), each attached to a behavioural async SRAM.
// Undriven data buses are pulled up, so a floating DQ reads as 16'hFFFF.
module tb_sram_controller;

`ifdef SRAM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r_en, w_en, sel;
  logic [17:0] addr;
  logic [31:0] wdata;
  logic        r_en1, w_en1, r_en3, w_en3;

  logic [63:0] rdata1, rdata3;
  logic        ready1, ready3;
  logic [17:0] addr1, addr3;
  logic        we1, oe1, ce1, ub1, lb1;
  logic        we3, oe3, ce3, ub3, lb3;
  wire  [15:0] dq1, dq3;

  logic [15:0] mem1 [0:262143];
  logic [15:0] mem3 [0:262143];

  assign r_en1 = r_en & ~sel;
  assign w_en1 = w_en & ~sel;
  assign r_en3 = r_en & sel;
  assign w_en3 = w_en & sel;

  sram_controller #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .sram_address(addr), .sram_wdata(wdata),
    .sram_r_en(r_en1), .sram_w_en(w_en1), .sram_rdata(rdata1), .sram_ready(ready1),
    .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1),
    .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
  );

  sram_controller #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .sram_address(addr), .sram_wdata(wdata),
    .sram_r_en(r_en3), .sram_w_en(w_en3), .sram_rdata(rdata3), .sram_ready(ready3),
    .SRAM_DQ(dq3), .SRAM_ADDR(addr3), .SRAM_WE_N(we3), .SRAM_OE_N(oe3),
    .SRAM_CE_N(ce3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3)
  );

  pullup (dq1);
  pullup (dq3);

  // Behavioural async SRAMs: combinational read, write captured each WE_N-low edge.
  assign dq1 = (oe1 === 1'b0 && we1 === 1'b1) ? mem1[addr1] : 16'hzzzz;
  assign dq3 = (oe3 === 1'b0 && we3 === 1'b1) ? mem3[addr3] : 16'hzzzz;
  always @(posedge clk) if (we1 === 1'b0) mem1[addr1] <= dq1;
  always @(posedge clk) if (we3 === 1'b0) mem3[addr3] <= dq3;

  // Observation muxes onto whichever instance is selected.
  logic        o_ready, o_we, o_oe;
  logic [17:0] o_addr;
  logic [63:0] o_rdata;
  wire  [15:0] o_dq;
  assign o_ready = sel ? ready3 : ready1;
  assign o_we    = sel ? we3 : we1;
  assign o_oe    = sel ? oe3 : oe1;
  assign o_addr  = sel ? addr3 : addr1;
  assign o_rdata = sel ? rdata3 : rdata1;
  assign o_dq    = sel ? dq3 : dq1;

  typedef struct {
    logic        rd;
    int          w;
    logic [17:0] base;
    logic [31:0] wd;
    logic [63:0] line;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  logic [63:0] last_line [2];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rd, input logic [17:0] a, input logic [31:0] wd,
                      input logic [63:0] xline);
    exp_t e;
    e.rd = rd;
    e.w  = sel ? 3 : 1;
    e.wd = wd;
    if (rd) begin
      e.base = {1'b0, a[17:3], 2'b00};
      e.line = xline;
      e.lat  = 4 * e.w + 1;
      last_line[sel] = xline;
    end else begin
      e.base = {1'b0, a[17:2], 1'b0};
      e.line = last_line[sel];
      e.lat  = POSTED ? 1 : 2 * e.w + 1;
    end
    sb.push_back(e);
  endtask

  // Called #1 after the acceptance edge (cycle 1); returns in cycle nph*w+3.
  task automatic watch(input string tag, input int drop_at);
    exp_t        e;
    int          nph, win, bad, rdy_cnt, rdy_at, ph;
    logic [17:0] ea;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: got empty scoreboard expected entry", tag);
      return;
    end
    e = sb.pop_front();
    nph = e.rd ? 4 : 2;
    win = nph * e.w + 3;
    bad = 0; rdy_cnt = 0; rdy_at = 0;
    for (int i = 1; i <= win; i++) begin
      if (i <= nph * e.w) begin
        ph = (i - 1) / e.w;
        ea = e.base + 18'(ph);
        if (o_addr !== ea) bad++;
        if (e.rd) begin
          if (o_oe !== 1'b0 || o_we !== 1'b1) bad++;
        end else begin
          if (o_we !== 1'b0 || o_oe !== 1'b1) bad++;
          if (o_dq !== ((ph == 0) ? e.wd[15:0] : e.wd[31:16])) bad++;
        end
      end else if (i == nph * e.w + 1) begin
        if (o_we !== 1'b1 || o_oe !== 1'b1 || o_dq !== 16'hFFFF) bad++;
      end
      if (i < win && o_ready === 1'b1) begin
        rdy_cnt++;
        if (rdy_at == 0) rdy_at = i;
      end
      if ((drop_at == 0 && o_ready === 1'b1) || (drop_at > 0 && i == drop_at)) begin
        r_en = 1'b0;
        w_en = 1'b0;
      end
      if (i < win) begin
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_trace"}, 64'(bad), 64'd0);
    check({tag, "_ready_count"}, 64'(rdy_cnt), 64'd1);
    check({tag, "_latency"}, 64'(rdy_at), 64'(e.lat));
    check({tag, "_rdata"}, o_rdata, e.line);
  endtask

  task automatic op(input string tag, input logic rd, input logic wr, input logic [17:0] a,
                    input logic [31:0] wd, input logic [63:0] xline, input int drop_at);
    push(rd & ~wr, a, wd, xline);
    addr = a; wdata = wd; r_en = rd; w_en = wr;
    @(posedge clk);
    #1;
    if (drop_at >= 0) begin
      addr  = ~a;
      wdata = ~wd;
    end
    watch(tag, drop_at);
  endtask

  initial begin
    int pulses;
    int acc_at;
    rst = 1'b0; r_en = 1'b0; w_en = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
    last_line[0] = '0;
    last_line[1] = '0;
    mem1[18'h08] <= 16'h1111; mem1[18'h09] <= 16'h2222;
    mem1[18'h0A] <= 16'h3333; mem1[18'h0B] <= 16'h4444;
    mem1[18'h10] <= 16'h5555; mem1[18'h11] <= 16'h6666;
    mem3[18'h08] <= 16'h1111; mem3[18'h09] <= 16'h2222;
    mem3[18'h0A] <= 16'h3333; mem3[18'h0B] <= 16'h4444;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready1), 64'd0);
    check("rst_we_n", 64'(we1), 64'd1);
    check("rst_oe_n", 64'(oe1), 64'd1);
    check("rst_addr", 64'(addr1), 64'd0);
    check("rst_rdata", rdata1, 64'd0);
    check("rst_dq_float", 64'(dq1), 64'hFFFF);
    check("ce_ub_lb", 64'({ce1, ub1, lb1, ce3, ub3, lb3}), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", 64'(ready1), 64'd0);
    check("idle_pins", 64'({we1, oe1}), 64'b11);
    check("idle_dq_float", 64'(dq1), 64'hFFFF);

    op("rd_w1", 1'b1, 1'b0, 18'h00010, 32'h0, 64'h4444_3333_2222_1111, 0);
    op("wr_w1", 1'b0, 1'b1, 18'h00024, 32'hDEAD_BEEF, 64'h0, 0);
    check("wr_w1_mem_lo", 64'(mem1[18'h12]), 64'hBEEF);
    check("wr_w1_mem_hi", 64'(mem1[18'h13]), 64'hDEAD);
    op("rdback_w1", 1'b1, 1'b0, 18'h00020, 32'h0, 64'hDEAD_BEEF_6666_5555, 0);

    sel = 1'b1;
    op("rd_w3", 1'b1, 1'b0, 18'h00010, 32'h0, 64'h4444_3333_2222_1111, 0);
    op("wr_w3_drop", 1'b0, 1'b1, 18'h00040, 32'h0BAD_F00D, 64'h0, 1);
    check("wr_w3_mem_lo", 64'(mem3[18'h20]), 64'hF00D);
    check("wr_w3_mem_hi", 64'(mem3[18'h21]), 64'h0BAD);

    sel = 1'b0;
    op("both_a", 1'b1, 1'b1, 18'h00030, 32'h1234_5678, 64'h0, -1);
    push(1'b0, 18'h00030, 32'h1234_5678, 64'h0);
    watch("both_b", 0);
    check("both_mem_lo", 64'(mem1[18'h18]), 64'h5678);
    check("both_mem_hi", 64'(mem1[18'h19]), 64'h1234);

    // Reset in the middle of read phase 2 on the slow instance.
    sel = 1'b1; addr = 18'h00010; r_en = 1'b1;
    @(posedge clk);
    #1;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    check("mid_phase2_addr", 64'(addr3), 64'h0A);
    rst = 1'b0;
    #1;
    r_en = 1'b0;
    check("abort_ready", 64'(ready3), 64'd0);
    check("abort_pins", 64'({we3, oe3}), 64'b11);
    check("abort_addr", 64'(addr3), 64'd0);
    check("abort_rdata", rdata3, 64'd0);
    check("abort_dq_float", 64'(dq3), 64'hFFFF);
    last_line[0] = '0;
    last_line[1] = '0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ready1 === 1'b1 || ready3 === 1'b1) pulses++;
      if (i == 1) rst = 1'b1;
    end
    check("abort_no_ready", 64'(pulses), 64'd0);
    check("abort_rdata_after", rdata1, 64'd0);

`ifdef SRAM_POSTED_WRITE_EN
    // Posted write: early ack, and a read raised in cycle 2 waits for IDLE.
    sel = 1'b0; addr = 18'h00050; wdata = 32'hCAFE_F00D; w_en = 1'b1;
    @(posedge clk);
    #1;
    check("pw_ready_c1", 64'(ready1), 64'd1);
    w_en = 1'b0;
    @(posedge clk);
    #1;
    check("pw_ready_c2", 64'(ready1), 64'd0);
    addr = 18'h00010; r_en = 1'b1;
    push(1'b1, 18'h00010, 32'h0, 64'h4444_3333_2222_1111);
    acc_at = 0; pulses = 0;
    for (int i = 3; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (oe1 === 1'b0) begin
        acc_at = i;
        break;
      end
      if (ready1 === 1'b1) pulses++;
    end
    check("pw_read_start", 64'(acc_at), 64'd5);
    check("pw_no_second_ready", 64'(pulses), 64'd0);
    check("pw_mem_lo", 64'(mem1[18'h28]), 64'hF00D);
    check("pw_mem_hi", 64'(mem1[18'h29]), 64'hCAFE);
    watch("pw_read", 0);
`else
    acc_at = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

endmodule
